fifo_wptr_full_ctrl: RTL
========================

Name: fifo_wptr_full_ctrl

Overview:
Write-domain pointer and full-flag controller for the async FIFO (DEPTH = 2**ADDR_W entries).
- Keeps the binary write pointer and produces the registered Gray write pointer. That Gray pointer is what the read-domain 2-flop synchroniser samples.
- Consumes the read Gray pointer after it has been synchronised into the write domain.
- Generates the memory write address and accept strobe, plus full, almost-full, fill level and a sticky overflow flag.

Parameters:
ADDR_W, 3, memory address width; pointers are ADDR_W+1 bits wide; DEPTH = 2**ADDR_W.
AF_THRESH, 6, fill level (0..DEPTH) at or above which almost_full asserts.

Ports:
clk  in  1  write-domain clock.
rst_n  in  1  reset, asynchronous, active-low.
wr_en  in  1  write request from the producer.
rq_ptr_sync  in  ADDR_W+1  read Gray pointer, already synchronised into the clk domain.
ovf_clr  in  1  clears the overflow flag.
wr_accept  out  1  combinational: wr_en & ~full; drives the memory write enable.
w_addr  out  ADDR_W  memory write address = wbin[ADDR_W-1:0] (register-driven).
w_gptr  out  ADDR_W+1  registered Gray write pointer, to the read-side synchroniser.
full  out  1  registered full flag.
almost_full  out  1  registered: level >= AF_THRESH.
wr_level  out  ADDR_W+1  registered fill level, 0..DEPTH.
overflow  out  1  sticky: set on a write attempt while full.

Behaviour:
- State registers: wbin[ADDR_W:0], w_gptr, full, almost_full, wr_level, overflow.
- Reset: all state clears to 0 immediately on rst_n low, independent of clk. With AF_THRESH=0, almost_full is 0 during reset and 1 from the first clock after reset.
- Write handshake:
  - push = wr_en & ~full.
  - wbin_next = wbin + push, wrapping modulo 2**(ADDR_W+1).
  - gnext = (wbin_next >> 1) ^ wbin_next.
  - At each clk edge: wbin <= wbin_next; w_gptr <= gnext.
- w_gptr changes at most one bit per clock. This is the mandatory CDC property; it must never glitch, since it comes straight from a flop.
- Full flag:
  - full <= (gnext == {~rq_ptr_sync[ADDR_W:ADDR_W-1], rq_ptr_sync[ADDR_W-2:0]}).
  - full is computed from next-state values, so it asserts on the clock edge that accepts the DEPTH-th outstanding write, with zero-cycle lag.
- Level:
  - rbin = gray2bin(rq_ptr_sync).
  - wr_level <= wbin_next - rbin, computed modulo 2**(ADDR_W+1), always in 0..DEPTH.
  - almost_full <= (wbin_next - rbin) >= AF_THRESH.
- Pessimism: rq_ptr_sync lags the true read pointer by two or more clk cycles. full, almost_full and wr_level may therefore overstate occupancy, but never understate it.
- Release: full deasserts on the first edge after rq_ptr_sync advances.
- Write while full: pointer unchanged, wr_accept=0, overflow <= 1.
- overflow clearing: ovf_clr clears overflow on the next edge. If a set and a clear occur in the same cycle, set wins.
- Simultaneous events: a write accept and a read-pointer advance in the same cycle leave the level unchanged, computed from both next values.
- rq_ptr_sync stability: assumed stable between edges, because it comes from the synchroniser flops. No internal re-synchronisation.
- Reset mid-operation: all outputs return to 0 asynchronously. The first write after reset release uses w_addr=0.

Decomposition:
- Shared package fifo_pkg holds:
  - ADDR_W default;
  - PTR_W = ADDR_W+1;
  - functions bin2gray and gray2bin (PTR_W-wide).
  The read-side controller uses the same package.
- One sub-module, gray2bin_conv: combinational, parameter W, XOR-prefix conversion. It is instantiated for rq_ptr_sync.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately. Release -> w_addr=0, full=0.
2. Fill from empty: rq_ptr_sync=0000, wr_en=1 for 8 cycles.
   - w_gptr must step 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100.
   - full=1 and wr_level=8 on the edge accepting the 8th write.
   - almost_full=1 from the 6th accept.
3. Overflow: while full, pulse wr_en for 2 cycles.
   - w_gptr stays 1100, wr_accept=0, overflow=1.
   - ovf_clr=1 alone -> overflow=0 next edge.
   - ovf_clr together with wr_en while full -> overflow stays 1.
4. Drain release: while full, set rq_ptr_sync=0001 -> next edge full=0, wr_level=7, almost_full=1. Then set rq_ptr_sync=0010 -> wr_level=5, almost_full=0.
5. Wrap-around:
   - Set rq_ptr_sync=1100 (binary 8) -> wr_level=0.
   - Write 8 more -> w_gptr returns to 0000, w_addr wraps 7->0, full=1.
   - Check w_gptr Hamming distance is 1 on every change.
6. Simultaneous: at level 4, wr_en=1 while rq_ptr_sync advances by 1 in the same cycle -> wr_level stays 4, full=0, w_addr increments.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width, pointer width and
// Gray/binary helpers used by both the write- and read-side controllers.
package fifo_pkg;

  localparam int ADDR_W = 3;
  localparam int PTR_W  = ADDR_W + 1;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] gray);
    logic [PTR_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < PTR_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_ctrl_gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin_conv #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < W; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/fifo_wptr_full_ctrl.sv
// Async FIFO write-side controller: binary/Gray write pointer, full,
// almost-full, fill level and sticky overflow, all in the clk domain.
module fifo_wptr_full_ctrl #(
  parameter int ADDR_W    = fifo_pkg::ADDR_W,
  parameter int AF_THRESH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rq_ptr_sync,
  input  logic              ovf_clr,
  output logic              wr_accept,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W:0]   w_gptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  import fifo_pkg::*;

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] gptr_q, gptr_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] rbin;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          push;

  gray2bin_conv #(.W(PW)) u_rq_conv (
    .gray_i (rq_ptr_sync),
    .bin_o  (rbin)
  );

  // Flags are derived from next-state pointers so full asserts on the
  // very edge that accepts the DEPTH-th write.
  always_comb begin
    push    = wr_en & ~full_q;
    wbin_d  = wbin_q + PW'(push);
    gptr_d  = (wbin_d >> 1) ^ wbin_d;
    level_d = wbin_d - rbin;
    full_d  = (gptr_d == {~rq_ptr_sync[PW-1:PW-2], rq_ptr_sync[PW-3:0]});
    af_d    = (32'(level_d) >= AF_THRESH);
    ovf_d   = (wr_en & full_q) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      gptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      gptr_q  <= gptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_accept   = push;
  assign w_addr      = wbin_q[ADDR_W-1:0];
  assign w_gptr      = gptr_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign wr_level    = level_q;
  assign overflow    = ovf_q;

endmodule
